// File: rtl/hex_display_scanner.sv
// Time-multiplexed seven-segment scanner with double-buffered digits,
// inter-digit blanking gaps and optional leading-zero suppression.
module seven_segment_decoder (
  input  logic [3:0] i_nib,
  output logic [6:0] o_seg
);
  always_comb begin
    case (i_nib)
      4'h0: o_seg = 7'b1111110;
      4'h1: o_seg = 7'b0000110;
      4'h2: o_seg = 7'b1011011;
      4'h3: o_seg = 7'b1001111;
      4'h4: o_seg = 7'b0100111;
      4'h5: o_seg = 7'b1101101;
      4'h6: o_seg = 7'b1111101;
      4'h7: o_seg = 7'b1000110;
      4'h8: o_seg = 7'b1111111;
      4'h9: o_seg = 7'b1101111;
      4'hA: o_seg = 7'b1110111;
      4'hB: o_seg = 7'b0111101;
      4'hC: o_seg = 7'b1111000;
      4'hD: o_seg = 7'b0011111;
      4'hE: o_seg = 7'b1111001;
      default: o_seg = 7'b1110001;
    endcase
  end
endmodule

module hex_display_scanner #(
  parameter int DIGITS           = 4,
  parameter int DWELL            = 1024,
  parameter int BLANK            = 16,
  parameter int ANODE_ACTIVE_LOW = 1
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic [4*DIGITS-1:0]   i_value,
  input  logic [DIGITS-1:0]     i_dp,
  input  logic                  i_load,
  input  logic                  i_blank_lz,
  output logic [6:0]            o_seg,
  output logic                  o_seg_dp,
  output logic [DIGITS-1:0]     o_digit_sel,
  output logic                  o_frame_done,
  output logic                  o_pending
);
  localparam int MAXC = (DWELL > BLANK) ? DWELL : BLANK;
  localparam int CW   = $clog2(MAXC + 1);
  localparam int IW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int VW   = 4 * DIGITS;
  localparam logic POL = (ANODE_ACTIVE_LOW != 0);
  localparam logic [DIGITS-1:0] SEL_OFF = {DIGITS{POL}};
  localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);

  typedef enum logic {SHOW, GAP} state_t;

  state_t              r_state;
  logic [CW-1:0]       r_cnt;
  logic [IW-1:0]       r_idx;
  logic                r_first;
  logic [VW-1:0]       r_sh_val;
  logic [VW-1:0]       r_act_val;
  logic [DIGITS-1:0]   r_sh_dp;
  logic [DIGITS-1:0]   r_act_dp;
  logic                r_pending;

  state_t              w_nxt_state;
  logic [CW-1:0]       w_nxt_cnt;
  logic [IW-1:0]       w_nxt_idx;
  logic                w_nxt_first;
  logic                w_cnt_one;
  logic                w_end;
  logic                w_commit;
  logic [VW-1:0]       w_nxt_val;
  logic [DIGITS-1:0]   w_nxt_dp;
  logic [3:0]          w_nib;
  logic [DIGITS:0]     w_zab;
  logic                w_blank;
  logic [DIGITS-1:0]   w_onehot;
  logic [DIGITS-1:0]   w_sel;
  logic                w_fd;
  logic [6:0]          w_dec;

  always_comb begin
    w_cnt_one   = (r_cnt == CW'(1));
    w_end       = (r_state == GAP) && w_cnt_one
                  && (r_idx == LAST) && !r_first;
    w_nxt_state = r_state;
    w_nxt_cnt   = r_cnt - CW'(1);
    w_nxt_idx   = r_idx;
    w_nxt_first = r_first;
    if (w_cnt_one) begin
      if (r_state == SHOW) begin
        w_nxt_state = GAP;
        w_nxt_cnt   = CW'(BLANK);
      end else begin
        w_nxt_state = SHOW;
        w_nxt_cnt   = CW'(DWELL);
        w_nxt_first = 1'b0;
        // the power-up gap leads into digit 0 without advancing
        if (!r_first)
          w_nxt_idx = (r_idx == LAST) ? '0 : r_idx + IW'(1);
      end
    end
    w_commit  = w_end && r_pending;
    w_nxt_val = w_commit ? r_sh_val : r_act_val;
    w_nxt_dp  = w_commit ? r_sh_dp  : r_act_dp;
    w_nib     = w_nxt_val[{w_nxt_idx, 2'b00} +: 4];
    w_zab[DIGITS] = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--)
      w_zab[i] = w_zab[i+1] & (w_nxt_val[4*i +: 4] == 4'h0);
    w_blank  = i_blank_lz && (w_nxt_idx != '0) && w_zab[w_nxt_idx];
    w_onehot = '0;
    w_onehot[w_nxt_idx] = 1'b1;
    w_sel    = (w_nxt_state == SHOW) ? w_onehot : '0;
    w_fd     = (w_nxt_state == GAP) && (w_nxt_cnt == CW'(1))
               && (w_nxt_idx == LAST) && !w_nxt_first;
  end

  seven_segment_decoder u_dec (
    .i_nib (w_nib),
    .o_seg (w_dec)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= GAP;
      r_cnt        <= CW'(BLANK);
      r_idx        <= '0;
      r_first      <= 1'b1;
      r_sh_val     <= '0;
      r_act_val    <= '0;
      r_sh_dp      <= '0;
      r_act_dp     <= '0;
      r_pending    <= 1'b0;
      o_seg        <= '0;
      o_seg_dp     <= 1'b0;
      o_digit_sel  <= SEL_OFF;
      o_frame_done <= 1'b0;
    end else begin
      r_state   <= w_nxt_state;
      r_cnt     <= w_nxt_cnt;
      r_idx     <= w_nxt_idx;
      r_first   <= w_nxt_first;
      r_act_val <= w_nxt_val;
      r_act_dp  <= w_nxt_dp;
      if (i_load) begin
        r_sh_val  <= i_value;
        r_sh_dp   <= i_dp;
        r_pending <= 1'b1;
      end else if (w_end) begin
        r_pending <= 1'b0;
      end
      o_digit_sel  <= w_sel ^ SEL_OFF;
      o_seg        <= (w_nxt_state == SHOW && !w_blank) ? w_dec : 7'd0;
      o_seg_dp     <= (w_nxt_state == SHOW) ? w_nxt_dp[w_nxt_idx] : 1'b0;
      o_frame_done <= w_fd;
    end
  end

  assign o_pending = r_pending;
endmodule

// File: tb/tb_hex_display_scanner.sv
// Scoreboard bench for hex_display_scanner (4 digits, dwell 4, gap 2).
// A cycle-position model predicts every output cycle.
module tb_hex_display_scanner;
  localparam int D  = 4;
  localparam int DW = 4;
  localparam int BL = 2;
  localparam int SL = DW + BL;
  localparam int FR = D * SL;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] val = '0;
  logic [3:0]  dpi = '0;
  logic        ld  = 1'b0;
  logic        blz = 1'b0;
  logic [6:0]  o_seg;
  logic        o_seg_dp;
  logic [3:0]  o_digit_sel;
  logic        o_frame_done;
  logic        o_pending;

  hex_display_scanner #(
    .DIGITS(D), .DWELL(DW), .BLANK(BL), .ANODE_ACTIVE_LOW(1)
  ) dut (
    .i_clk        (clk),
    .i_reset      (rst),
    .i_value      (val),
    .i_dp         (dpi),
    .i_load       (ld),
    .i_blank_lz   (blz),
    .o_seg        (o_seg),
    .o_seg_dp     (o_seg_dp),
    .o_digit_sel  (o_digit_sel),
    .o_frame_done (o_frame_done),
    .o_pending    (o_pending)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int t = 0;
  logic [15:0] msh = '0;
  logic [15:0] mact = '0;
  logic [3:0]  mshdp = '0;
  logic [3:0]  mactdp = '0;
  logic        mpend = 1'b0;
  logic [13:0] q[$];

  function automatic logic [6:0] dec(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'b1111110;
      4'h1: s = 7'b0000110;
      4'h2: s = 7'b1011011;
      4'h3: s = 7'b1001111;
      4'h4: s = 7'b0100111;
      4'h5: s = 7'b1101101;
      4'h6: s = 7'b1111101;
      4'h7: s = 7'b1000110;
      4'h8: s = 7'b1111111;
      4'h9: s = 7'b1101111;
      4'hA: s = 7'b1110111;
      4'hB: s = 7'b0111101;
      4'hC: s = 7'b1111000;
      4'hD: s = 7'b0011111;
      4'hE: s = 7'b1111001;
      default: s = 7'b1110001;
    endcase
    return s;
  endfunction

  function automatic bit is_end(input int tt);
    return (tt >= 2) && ((tt - 2) % FR == FR - 1);
  endfunction

  // {digit_sel, seg, seg_dp, frame_done, pending}
  function automatic logic [13:0] expect_out(input int tt, input logic bz);
    logic [13:0] r;
    logic [3:0]  s;
    logic [15:0] hi;
    int p, d;
    r = {4'hF, 7'd0, 1'b0, 1'b0, mpend};
    if (tt >= 2) begin
      p = (tt - 2) % FR;
      d = p / SL;
      if (p % SL < DW) begin
        s = 4'b0001 << d;
        r[13:10] = ~s;
        hi = mact >> (4 * d);
        if (!(bz && d > 0 && hi == 16'h0))
          r[9:3] = dec(mact[4*d +: 4]);
        r[2] = mactdp[d];
      end
      r[1] = is_end(tt);
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h t=%0d", tag, obs, exp, t);
    end
  endtask

  task automatic tick();
    bit was_end;
    logic [13:0] o;
    logic [13:0] e;
    @(posedge clk);
    if (rst) begin
      t = 0; msh = '0; mact = '0; mshdp = '0; mactdp = '0; mpend = 1'b0;
    end else begin
      was_end = is_end(t);
      if (was_end && mpend) begin
        mact = msh; mactdp = mshdp;
      end
      if (ld) begin
        msh = val; mshdp = dpi; mpend = 1'b1;
      end else if (was_end) begin
        mpend = 1'b0;
      end
      t++;
    end
    q.push_back(expect_out(t, blz));
    #1;
    o = {o_digit_sel, o_seg, o_seg_dp, o_frame_done, o_pending};
    e = q.pop_front();
    chk("cycle", 32'(o), 32'(e));
  endtask

  task automatic run_to(input int p);
    bit found;
    found = 1'b0;
    for (int k = 0; k < 2 * FR && !found; k++) begin
      tick();
      if (t >= 2 && (t - 2) % FR == p) found = 1'b1;
    end
    chk("run_to", 32'(found), 32'd1);
  endtask

  task automatic load(input logic [15:0] v, input logic [3:0] d);
    val = v; dpi = d; ld = 1'b1;
    tick();
    ld = 1'b0;
  endtask

  initial begin
    repeat (3) tick();
    chk("rst_sel", 32'(o_digit_sel), 32'hF);
    chk("rst_seg", 32'(o_seg), 32'h0);
    chk("rst_fd", 32'(o_frame_done), 32'h0);
    chk("rst_pend", 32'(o_pending), 32'h0);
    rst = 1'b0;
    tick();
    chk("gap0_sel", 32'(o_digit_sel), 32'hF);
    tick();
    chk("show0_sel", 32'(o_digit_sel), 32'hE);
    chk("show0_seg", 32'(o_seg), 32'h7E);
    run_to(23);
    chk("fd_pulse", 32'(o_frame_done), 32'h1);
    tick();
    chk("fd_drop", 32'(o_frame_done), 32'h0);

    run_to(8);
    load(16'h12AF, 4'b0100);
    chk("pend_rise", 32'(o_pending), 32'h1);
    run_to(12);
    chk("old_d2", 32'(o_seg), 32'h7E);
    run_to(0);
    chk("new_d0", 32'(o_seg), 32'(7'b1110001));
    chk("pend_clr", 32'(o_pending), 32'h0);
    run_to(12);
    chk("new_d2", 32'(o_seg), 32'(7'b1011011));
    chk("new_d2_dp", 32'(o_seg_dp), 32'h1);
    chk("new_d2_sel", 32'(o_digit_sel), 32'hB);

    run_to(3);
    load(16'h1111, 4'h0);
    tick();
    load(16'h2222, 4'h0);
    run_to(6);
    chk("two_ld_d1", 32'(o_seg), 32'(7'b1011011));

    run_to(5);
    load(16'h4444, 4'h0);
    run_to(23);
    load(16'h3333, 4'h0);
    chk("commit_pend", 32'(o_pending), 32'h1);
    chk("commit_4", 32'(o_seg), 32'(7'b0100111));
    run_to(23);
    tick();
    chk("then_3", 32'(o_seg), 32'(7'b1001111));
    chk("then_pend", 32'(o_pending), 32'h0);

    blz = 1'b1;
    load(16'h0050, 4'h0);
    run_to(0);
    run_to(6);
    chk("lz_d1", 32'(o_seg), 32'(7'b1101101));
    run_to(12);
    chk("lz_d2", 32'(o_seg), 32'h0);
    chk("lz_d2_sel", 32'(o_digit_sel), 32'hB);
    run_to(18);
    chk("lz_d3", 32'(o_seg), 32'h0);
    load(16'h0000, 4'h0);
    run_to(0);
    chk("lz0_d0", 32'(o_seg), 32'(7'b1111110));
    run_to(6);
    chk("lz0_d1", 32'(o_seg), 32'h0);
    run_to(23);

    blz = 1'b0;
    load(16'hABCD, 4'b1001);
    run_to(0);
    load(16'h5555, 4'h0);
    run_to(12);
    chk("pre_rst_pend", 32'(o_pending), 32'h1);
    rst = 1'b1;
    tick();
    chk("mid_rst_sel", 32'(o_digit_sel), 32'hF);
    chk("mid_rst_pend", 32'(o_pending), 32'h0);
    rst = 1'b0;
    run_to(0);
    run_to(6);
    chk("post_rst_d1", 32'(o_seg), 32'h7E);
    run_to(23);
    chk("post_rst_fd", 32'(o_frame_done), 32'h1);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/hex_display_scanner.md
# hex_display_scanner

Time-multiplexed driver for a common-anode/common-cathode multi-digit seven-segment display. It owns a single shared `seven_segment_decoder` and steps it across DIGITS hex nibbles, one digit per dwell period with a dead interval between digits to suppress ghosting. New values are double-buffered so the display never tears mid-frame. It sits between the CPU's output-port register and the board's segment/anode pins.

## Interface
- DIGITS, 4: number of display digits (1..8).
- DWELL, 1024: cycles each digit is lit (>=1).
- BLANK, 16: dead cycles between digits, all anodes off (>=1).
- ANODE_ACTIVE_LOW, 1: 1 = digit_sel active-low, 0 = active-high.
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- value  in  4*DIGITS  hex nibbles; nibble i = value[4i+3:4i], digit 0 least significant.
- dp  in  DIGITS  decimal-point enables, bit i for digit i.
- load  in  1  single-cycle strobe; captures value/dp into shadow.
- blank_lz  in  1  leading-zero suppression enable (sampled live).
- seg  out  7  segment drive, active-high, decoder bit order (6 top, 5 upper-left, 4 lower-left, 3 bottom, 2 lower-right, 1 upper-right, 0 middle).
- seg_dp  out  1  decimal point, active-high.
- digit_sel  out  DIGITS  one-hot anode enables (polarity per ANODE_ACTIVE_LOW).
- frame_done  out  1  one-cycle pulse at end of each frame.
- pending  out  1  shadow holds a value not yet committed.

## Operation
- Registers: shadow value/dp, active value/dp, pending, digit index idx (0..DIGITS-1), state {SHOW, GAP}, down-counter cnt sized for max(DWELL,BLANK).
- load=1: shadow <= value/dp, pending <= 1. Loads while pending overwrite shadow (last wins).
- SHOW: digit_sel selects idx, seg = decoder(active nibble idx) unless blanked, seg_dp = active dp[idx]. After DWELL cycles -> GAP.
- GAP: digit_sel all inactive, seg = 0, seg_dp = 0. After BLANK cycles -> SHOW with idx+1; if idx was DIGITS-1, idx wraps to 0 and frame ends.
- Frame end (last GAP cycle of idx DIGITS-1): frame_done pulses; if pending, active <= shadow, pending <= 0 (commit).
- Load in the commit cycle: commit takes the shadow contents from before this cycle; the new load lands in shadow and pending remains 1 (committed next frame).
- Leading-zero blanking: digit i>0 blanked (seg = 0) when blank_lz=1 and active nibbles i..DIGITS-1 are all zero. Digit 0 never blanked. seg_dp and digit_sel unaffected by blanking.
- Decoder is combinational; seg, seg_dp, digit_sel are registered from the same state so they change on the same edge.

## Timing
- Reset: state GAP, cnt = BLANK, idx = 0, active = shadow = 0, pending = 0, seg = 0, seg_dp = 0, digit_sel all inactive, frame_done = 0.
- First digit-0 SHOW begins BLANK cycles after reset deasserts; that initial GAP does not end a frame.
- Frame length exactly DIGITS*(DWELL+BLANK) cycles; SHOW for digit i lasts exactly DWELL cycles, every GAP exactly BLANK cycles.
- pending rises the cycle after load; active change first visible on digit 0's SHOW following frame_done.
- Never more than one digit_sel bit active; no cycle where digit_sel changes from one digit directly to another.
- Reset mid-frame: all state returns to reset values on the next edge regardless of state; an uncommitted shadow is discarded.

## Test plan
- DIGITS=4, DWELL=4, BLANK=2: after reset, check 2 gap cycles then digit_sel=1110 (active-low) for 4 cycles, 2 gap cycles, 1101 ... ; frame_done every 24 cycles.
- load value=16'h12AF, dp=4'b0100 mid-frame: pending=1 next cycle; display keeps old value until frame_done; next frame digit 0 seg=decoder(F), digit 2 seg=decoder(2) with seg_dp=1; pending=0.
- Two loads (16'h1111 then 16'h2222) in one frame: next frame shows 2222 on all digits.
- Load 16'h3333 exactly in commit cycle with prior shadow 16'h4444: next frame shows 4444, pending stays 1, frame after shows 3333.
- blank_lz=1, value=16'h0050: digits 3,2 seg=0, digit 1 seg=decoder(5), digit 0 seg=decoder(0); value=0 -> only digit 0 lit showing 0.
- Assert reset during digit 2 SHOW with pending=1: next cycle outputs at reset values, pending=0, following frame shows 0000.
